// File: rtl/npc_mem_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner and mask constants.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    typedef enum logic {
        OwnIf,
        OwnLs
    } owner_e;

    localparam int unsigned MaskW = 8;
    localparam logic [MaskW-1:0] IfMask = 8'hFF;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and LS requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise LS priority with an IF starvation guard.
module mem_arb_pick
    import npc_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CntW       = $clog2(STARVE_MAX + 1)
) (
    input  logic            if_valid_i,
    input  logic            ls_valid_i,
    input  owner_e          last_owner_i,
    input  logic [CntW-1:0] starve_cnt_i,
    output logic            grant_if_o,
    output logic            grant_ls_o
);

    localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

`ifdef MEM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = ^starve_cnt_i;

    always_comb begin
        grant_if_o = if_valid_i;
        grant_ls_o = ls_valid_i;
        if (if_valid_i && ls_valid_i) begin
            // Alternate: whoever was not granted last goes now.
            grant_if_o = (last_owner_i == OwnLs);
            grant_ls_o = (last_owner_i == OwnIf);
        end
    end
`else
    logic unused_last;
    assign unused_last = (last_owner_i == OwnLs);

    always_comb begin
        grant_if_o = if_valid_i;
        grant_ls_o = ls_valid_i;
        if (if_valid_i && ls_valid_i) begin
            grant_if_o = (starve_cnt_i == StarveMaxC);
            grant_ls_o = (starve_cnt_i != StarveMaxC);
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and LS with a single outstanding transaction.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_resp_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              ls_req_valid_i,
    output logic              ls_req_ready_o,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              ls_wen_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [MaskW-1:0]  ls_mask_i,
    output logic              ls_resp_valid_o,
    output logic [DATA_W-1:0] ls_rdata_o,

    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [MaskW-1:0]  mem_mask_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MaskW-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic grant_if, grant_ls;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CntW       (CntW)
    ) u_pick (
        .if_valid_i   (if_req_valid_i),
        .ls_valid_i   (ls_req_valid_i),
        .last_owner_i (owner_q),
        .starve_cnt_i (starve_q),
        .grant_if_o   (grant_if),
        .grant_ls_o   (grant_ls)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        starve_d        = starve_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        mask_d          = mask_q;
        if_rdata_d      = if_rdata_q;
        ls_rdata_d      = ls_rdata_q;
        if_req_ready_o  = 1'b0;
        ls_req_ready_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        if_resp_valid_o = 1'b0;
        ls_resp_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if_req_ready_o = grant_if;
                ls_req_ready_o = grant_ls;
                if (grant_if) begin
                    addr_d   = if_addr_i;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    mask_d   = IfMask;
                    owner_d  = OwnIf;
                    starve_d = '0;
                    state_d  = StIssue;
                end else if (grant_ls) begin
                    addr_d  = ls_addr_i;
                    wen_d   = ls_wen_i;
                    wdata_d = ls_wdata_i;
                    mask_d  = ls_mask_i;
                    owner_d = OwnLs;
                    // Only LS wins taken over a waiting IF count toward starvation.
                    if (if_req_valid_i && (starve_q != StarveMaxC)) begin
                        starve_d = starve_q + CntW'(1);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid_i) begin
                    if (owner_q == OwnIf) begin
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        ls_rdata_d = wen_q ? '0 : mem_rdata_i;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                if_resp_valid_o = (owner_q == OwnIf);
                ls_resp_valid_o = (owner_q == OwnLs);
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            owner_q    <= OwnIf;
            starve_q   <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wen_o   = wen_q;
    assign mem_wdata_o = wdata_q;
    assign mem_mask_o  = mask_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases, random traffic.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_mask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .if_req_valid_i   (if_req_valid),
        .if_req_ready_o   (if_req_ready),
        .if_addr_i        (if_addr),
        .if_resp_valid_o  (if_resp_valid),
        .if_rdata_o       (if_rdata),
        .ls_req_valid_i   (ls_req_valid),
        .ls_req_ready_o   (ls_req_ready),
        .ls_addr_i        (ls_addr),
        .ls_wen_i         (ls_wen),
        .ls_wdata_i       (ls_wdata),
        .ls_mask_i        (ls_mask),
        .ls_resp_valid_o  (ls_resp_valid),
        .ls_rdata_o       (ls_rdata),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_wen_o        (mem_wen),
        .mem_wdata_o      (mem_wdata),
        .mem_mask_o       (mem_mask),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_rdata_i      (mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Arbitration reference: who has been granted, how many LS wins passed over a waiting IF.
    bit m_last_ls;
    int m_starve;

    function automatic bit ref_pick_ls(input bit ifv, input bit lsv);
        if (!ifv) return 1'b1;
        if (!lsv) return 1'b0;
`ifdef MEM_ARB_RR_EN
        return !m_last_ls;
`else
        return m_starve < STARVE_MAX;
`endif
    endfunction

    function automatic void ref_grant(input bit ls, input bit ifv);
        if (ls) begin
            if (ifv && m_starve < STARVE_MAX) m_starve++;
            m_last_ls = 1'b1;
        end else begin
            m_starve  = 0;
            m_last_ls = 1'b0;
        end
    endfunction

    task automatic idle_inputs();
        if_req_valid   = 1'b0;
        if_addr        = '0;
        ls_req_valid   = 1'b0;
        ls_addr        = '0;
        ls_wen         = 1'b0;
        ls_wdata       = '0;
        ls_mask        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni    = 1'b1;
        m_last_ls = 1'b0;
        m_starve  = 0;
    endtask

    typedef struct {
        bit          ifv;
        bit          lsv;
        bit          wen;
        logic [63:0] if_addr;
        logic [63:0] ls_addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
        bit          exp_ls;
    } vec_t;

    vec_t tbl [6];

    // One complete transaction from IDLE with an immediately ready memory.
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] e_addr, e_wdata, e_data;
        logic        e_wen;
        logic [7:0]  e_mask;
        e_addr  = v.exp_ls ? v.ls_addr : v.if_addr;
        e_wen   = v.exp_ls & v.wen;
        e_wdata = v.exp_ls ? v.wdata : 64'd0;
        e_mask  = v.exp_ls ? v.mask : 8'hFF;
        e_data  = e_wen ? 64'd0 : v.rdata;

        @(negedge clk_i);
        if_req_valid = v.ifv;
        if_addr      = v.if_addr;
        ls_req_valid = v.lsv;
        ls_addr      = v.ls_addr;
        ls_wen       = v.wen;
        ls_wdata     = v.wdata;
        ls_mask      = v.mask;
        #1;
        chk1($sformatf("v%0d_if_ready", idx), if_req_ready, v.ifv && !v.exp_ls);
        chk1($sformatf("v%0d_ls_ready", idx), ls_req_ready, v.exp_ls);

        @(negedge clk_i);
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk1($sformatf("v%0d_mem_req_valid", idx), mem_req_valid, 1'b1);
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, e_addr);
        chk1($sformatf("v%0d_mem_wen", idx), mem_wen, e_wen);
        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, e_wdata);
        chk($sformatf("v%0d_mem_mask", idx), 64'(mem_mask), 64'(e_mask));

        @(negedge clk_i);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = v.rdata;
        #1;
        chk1($sformatf("v%0d_mem_req_dropped", idx), mem_req_valid, 1'b0);

        @(negedge clk_i);
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk1($sformatf("v%0d_if_resp", idx), if_resp_valid, !v.exp_ls);
        chk1($sformatf("v%0d_ls_resp", idx), ls_resp_valid, v.exp_ls);
        chk($sformatf("v%0d_rdata", idx), v.exp_ls ? ls_rdata : if_rdata, e_data);

        @(negedge clk_i);
        #1;
        chk1($sformatf("v%0d_resp_gone", idx), if_resp_valid | ls_resp_valid, 1'b0);
        chk($sformatf("v%0d_rdata_hold", idx), v.exp_ls ? ls_rdata : if_rdata, e_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got [6];
        bit          exp_order [6];
        int          ng;
        bit          busy, issued, resp_due, resp_now, exp_mreq, exp_ifr, exp_lsr;
        bit          drop_if, drop_ls, cur_ls, cur_wen;
        int          wait_cnt;
        logic [63:0] cur_addr, cur_wdata, cur_data;
        logic [7:0]  cur_mask;

        tbl[0] = '{1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 64'h0000_0013_0000_0297, 0};
        tbl[1] = '{0, 1, 1, 64'h0, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h5555_5555, 1};
        tbl[2] = '{0, 1, 0, 64'h0, 64'h8000_2008, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 1};
        tbl[3] = '{1, 1, 0, 64'h8000_0004, 64'h8000_3000, 64'h0, 8'hF0, 64'hCAFE_F00D_0000_0001, 1};
        tbl[4] = '{1, 1, 1, 64'h8000_0008, 64'h8000_3010, 64'hA5A5_0000_1234, 8'h3C,
                   64'h0BAD_0000_0000_0002, 1};
        tbl[5] = '{1, 0, 0, 64'h8000_000C, 64'h0, 64'h0, 8'h00, 64'h0000_0000_0000_0073, 0};
`ifdef MEM_ARB_RR_EN
        tbl[3].exp_ls = 0;
        exp_order = '{1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1, 0, 1};
`endif

        // Reset state.
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_ls_ready", ls_req_ready, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_resp_valid", if_resp_valid | ls_resp_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_mask", 64'(mem_mask), 64'd0);
        chk("rst_rdata", if_rdata | ls_rdata, 64'd0);
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Both requesters held valid: grant order shows the priority/starvation rule.
        do_reset();
        @(negedge clk_i);
        if_req_valid   = 1'b1;
        if_addr        = 64'h8000_0100;
        ls_req_valid   = 1'b1;
        ls_addr        = 64'h8000_2100;
        ls_mask        = 8'hFF;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h77;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            #1;
            if (if_req_ready || ls_req_ready) begin
                got[ng] = ls_req_ready;
                ng++;
            end
            @(negedge clk_i);
        end
        chk("starve_grant_count", 64'(ng), 64'd6);
        for (int i = 0; i < ng; i++) begin
            chk1($sformatf("starve_grant%0d_is_ls", i), got[i], exp_order[i]);
        end

        // Memory stalls the request for five cycles.
        do_reset();
        @(negedge clk_i);
        if_req_valid = 1'b1;
        if_addr      = 64'h8000_0040;
        #1;
        chk1("stall_accept", if_req_ready, 1'b1);
        @(negedge clk_i);
        ls_req_valid = 1'b1;
        ls_addr      = 64'h8000_4000;
        if_addr      = 64'h8000_0080;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk1($sformatf("stall%0d_mem_req_valid", c), mem_req_valid, 1'b1);
            chk($sformatf("stall%0d_mem_addr", c), mem_addr, 64'h8000_0040);
            chk1($sformatf("stall%0d_if_ready", c), if_req_ready, 1'b0);
            chk1($sformatf("stall%0d_ls_ready", c), ls_req_ready, 1'b0);
            @(negedge clk_i);
        end
        mem_req_ready = 1'b1;
        @(negedge clk_i);
        if_req_valid   = 1'b0;
        ls_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk_i);
        mem_resp_valid = 1'b0;
        #1;
        chk1("stall_if_resp", if_resp_valid, 1'b1);
        chk("stall_if_rdata", if_rdata, 64'h1234_5678_9ABC_DEF0);

        // Reset asserted while waiting on memory; a late response must be dropped.
        do_reset();
        @(negedge clk_i);
        ls_req_valid = 1'b1;
        ls_addr      = 64'h8000_0100;
        ls_mask      = 8'hFF;
        #1;
        chk1("rwait_accept", ls_req_ready, 1'b1);
        @(negedge clk_i);
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk_i);
        mem_req_ready = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rwait_async_addr", mem_addr, 64'd0);
        chk("rwait_async_mask", 64'(mem_mask), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBAD;
        #1;
        chk1("rwait_no_resp0", if_resp_valid | ls_resp_valid, 1'b0);
        @(negedge clk_i);
        mem_resp_valid = 1'b0;
        #1;
        chk1("rwait_no_resp1", if_resp_valid | ls_resp_valid, 1'b0);
        chk1("rwait_mem_req_valid", mem_req_valid, 1'b0);
        chk("rwait_ls_rdata", ls_rdata, 64'd0);
        chk("rwait_mem_addr", mem_addr, 64'd0);
        if_req_valid = 1'b1;
        if_addr      = 64'h8000_0200;
        #1;
        chk1("rwait_idle_ready", if_req_ready, 1'b1);

        // Spurious memory response in IDLE.
        do_reset();
        @(negedge clk_i);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBADB_AD00;
        @(negedge clk_i);
        mem_resp_valid = 1'b0;
        #1;
        chk1("spur_no_resp", if_resp_valid | ls_resp_valid, 1'b0);
        chk("spur_if_rdata", if_rdata, 64'd0);
        run_vec(tbl[0], 10);

        // Random traffic against the transaction-level reference.
        do_reset();
        busy     = 0;
        issued   = 0;
        resp_due = 0;
        drop_if  = 0;
        drop_ls  = 0;
        wait_cnt = 0;
        cur_ls   = 0;
        cur_wen  = 0;
        cur_addr = '0;
        cur_wdata = '0;
        cur_data = '0;
        cur_mask = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk_i);
            if (drop_if) if_req_valid = 1'b0;
            if (drop_ls) ls_req_valid = 1'b0;
            drop_if = 0;
            drop_ls = 0;
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_addr      = {$urandom, $urandom};
            end
            if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
                ls_req_valid = 1'b1;
                ls_addr      = {$urandom, $urandom};
                ls_wen       = 1'($urandom_range(0, 1));
                ls_wdata     = {$urandom, $urandom};
                ls_mask      = 8'($urandom);
            end
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'b0;
            mem_rdata      = {$urandom, $urandom};
            resp_now       = 0;
            if (issued) begin
                if (wait_cnt == 0) begin
                    resp_now       = 1;
                    mem_resp_valid = 1'b1;
                    cur_data       = mem_rdata;
                    issued         = 0;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
            end
            #1;
            exp_mreq = busy && !issued && !resp_now && !resp_due;
            exp_ifr  = 0;
            exp_lsr  = 0;
            if (!busy && (if_req_valid || ls_req_valid)) begin
                exp_lsr = ref_pick_ls(if_req_valid, ls_req_valid);
                exp_ifr = !exp_lsr;
            end
            chk1("rnd_if_ready", if_req_ready, exp_ifr);
            chk1("rnd_ls_ready", ls_req_ready, exp_lsr);
            chk1("rnd_mem_req_valid", mem_req_valid, exp_mreq);
            chk1("rnd_if_resp", if_resp_valid, resp_due && !cur_ls);
            chk1("rnd_ls_resp", ls_resp_valid, resp_due && cur_ls);
            if (exp_mreq) begin
                chk("rnd_mem_addr", mem_addr, cur_addr);
                chk1("rnd_mem_wen", mem_wen, cur_wen);
                chk("rnd_mem_wdata", mem_wdata, cur_wdata);
                chk("rnd_mem_mask", 64'(mem_mask), 64'(cur_mask));
            end
            if (resp_due) begin
                if (cur_ls) chk("rnd_ls_rdata", ls_rdata, cur_wen ? 64'd0 : cur_data);
                else        chk("rnd_if_rdata", if_rdata, cur_data);
            end
            if (resp_due) begin
                busy     = 0;
                resp_due = 0;
            end else if (resp_now) begin
                resp_due = 1;
            end
            if (exp_mreq && mem_req_ready) begin
                issued   = 1;
                wait_cnt = $urandom_range(0, 3);
            end
            if (exp_ifr || exp_lsr) begin
                busy   = 1;
                cur_ls = exp_lsr;
                if (exp_lsr) begin
                    cur_addr  = ls_addr;
                    cur_wen   = ls_wen;
                    cur_wdata = ls_wdata;
                    cur_mask  = ls_mask;
                    drop_ls   = 1;
                end else begin
                    cur_addr  = if_addr;
                    cur_wen   = 0;
                    cur_wdata = '0;
                    cur_mask  = 8'hFF;
                    drop_if   = 1;
                end
                ref_grant(exp_lsr, if_req_valid);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical-memory port (DPI-backed pmem model) between the instruction fetch unit (IF) and the load/store unit (LS).
- Accepts one request at a time from either requester and registers it. It issues the request to memory with a valid/ready handshake, waits for the response, then routes the response back to the owner.
- Sits between IFU/LSU and the memory model; it replaces the direct combinational pmem calls with a sequenced, one-outstanding transaction.

Parameters:
- ADDR_W, 64, address width of every port
- DATA_W, 64, data width of every port
- STARVE_MAX, 4, number of consecutive LS grants after which a pending IF request wins the next arbitration (fixed-priority mode only)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF read request valid
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_W  IF read address
- if_resp_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  IF read data
- ls_req_valid  in  1  LS request valid
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_W  LS address
- ls_wen  in  1  1=write, 0=read
- ls_wdata  in  DATA_W  LS write data
- ls_mask  in  8  byte mask, forwarded unchanged
- ls_resp_valid  out  1  one-cycle pulse: read data valid, or write acknowledged
- ls_rdata  out  DATA_W  LS read data (0 for writes)
- mem_req_valid  out  1  request to memory valid
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_mask  out  ADDR_W/1/DATA_W/8  registered copy of granted request
- mem_resp_valid  in  1  memory response valid (single cycle)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all *_ready, *_resp_valid and mem_req_valid are 0; all data/address outputs are 0; starvation counter is 0; owner is IF. Any in-flight transaction is dropped; a late mem_resp_valid after reset release is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The arbiter picks a winner among the valid requesters. The winner's *_ready=1 combinationally; the loser's ready=0.
  - On accept: address, wen, wdata and mask are captured (IF: wen=0, mask=8'hFF, wdata=0); owner is recorded; next state is ISSUE.
  - With no valid request, the FSM stays in IDLE.
- Fixed-priority pick:
  - LS wins when both are valid, unless starve_cnt==STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each LS grant made while IF is valid, saturating at STARVE_MAX. It clears on any IF grant.
- ISSUE: mem_req_valid=1 with the registered fields held stable. When mem_req_ready=1, the FSM moves to WAIT. mem_req_valid stays high until the handshake completes.
- WAIT:
  - On mem_resp_valid, mem_rdata is latched (forced to 0 if the transaction is a write) and the FSM moves to RESP.
  - mem_resp_valid seen in IDLE or ISSUE is ignored.
- RESP: the owner's resp_valid=1 for exactly one cycle with its rdata; the non-owner's resp_valid=0; next state is IDLE. Requesters cannot back-pressure responses.
- Latency: accept at cycle N → mem_req_valid at N+1. With mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid is seen at N+3. Next accept is no earlier than N+4 (IDLE).
- Exactly one transaction outstanding; both *_ready are 0 outside IDLE.
- rdata outputs hold their last value between pulses.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin arbitration. When both requesters are valid, the one not granted last wins. starve_cnt and STARVE_MAX are unused.
- Undefined: fixed LS priority with the starvation guard described in Behaviour.

Decomposition:
- Package npc_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_IF, OWN_LS}
  - localparams for mask width (8) and the default IF mask (8'hFF)
- One sub-module, mem_arb_pick: combinational winner selection from {if_valid, ls_valid, last_owner, starve_cnt}. It contains the MEM_ARB_RR_EN switch.

Test Plan:
- Single IF read, addr=0x80000000, mem_rdata=0x00000013_00000297, mem_req_ready immediate → if_resp_valid one cycle at N+3 with that data; ls_resp_valid stays 0.
- LS write, addr=0x80001000, wdata=0xDEADBEEF, mask=8'h0F → mem_wen=1, mem_mask=8'h0F, mem_wdata matches; ls_resp_valid pulse with ls_rdata=0.
- IF and LS both valid continuously, fixed priority, STARVE_MAX=4 → grant order LS,LS,LS,LS,IF,LS…; with MEM_ARB_RR_EN → strict alternation starting with LS.
- mem_req_ready held 0 for 5 cycles → mem_req_valid and mem_addr stable all 5 cycles; if_req_ready and ls_req_ready stay 0.
- Reset asserted in WAIT, then mem_resp_valid pulse after release → no resp_valid on either requester; state IDLE; all outputs 0.
- Spurious mem_resp_valid in IDLE → ignored; no resp_valid pulse, state unchanged.
